// File: rtl/one_hot_step_sequencer.sv
// Timed one-hot sequencer: a prescaler tick steps an index up, down,
// bouncing or holding, and the index drives a registered one-hot output.
module one_hot_step_sequencer #(
    parameter int CLK_FREQ = 10_000_000,
    parameter int STEP_HZ  = 2,
    parameter int N_OUT    = 8,
    localparam int IDX_W   = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    output logic [N_OUT-1:0] decoder_out,
    output logic [IDX_W-1:0] idx,
    output logic             step_pulse,
    output logic             wrap_pulse
);

    localparam int PERIOD = CLK_FREQ / STEP_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_OUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [N_OUT-1:0] ONE_HOT0 = N_OUT'(1);

    typedef enum logic [1:0] {
        M_UP     = 2'b00,
        M_DOWN   = 2'b01,
        M_BOUNCE = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    logic [CNT_W-1:0] cnt;
    logic             dir_up;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_dir;
    logic             nxt_wrap;
    logic             tick;
    logic             load_ok;
    logic             moving;

    assign tick    = en && (cnt == '0);
    assign load_ok = load && (32'(load_idx) < 32'(N_OUT));
    assign moving  = (mode_e'(mode) != M_HOLD);

    always_comb begin
        nxt_idx  = idx;
        nxt_dir  = dir_up;
        nxt_wrap = 1'b0;
        unique case (mode_e'(mode))
            M_UP: begin
                nxt_wrap = (idx == IDX_MAX);
                nxt_idx  = nxt_wrap ? '0 : idx + IDX_ONE;
            end
            M_DOWN: begin
                nxt_wrap = (idx == '0);
                nxt_idx  = nxt_wrap ? IDX_MAX : idx - IDX_ONE;
            end
            M_BOUNCE: begin
                // Reversal reflects off the end rather than dwelling on it.
                if (dir_up) begin
                    nxt_wrap = (idx == IDX_MAX);
                    nxt_idx  = nxt_wrap ? IDX_MAX - IDX_ONE : idx + IDX_ONE;
                    nxt_dir  = !nxt_wrap;
                end else begin
                    nxt_wrap = (idx == '0);
                    nxt_idx  = nxt_wrap ? IDX_ONE : idx - IDX_ONE;
                    nxt_dir  = nxt_wrap;
                end
            end
            M_HOLD: begin
                nxt_idx = idx;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= CNT_MAX;
            idx         <= '0;
            dir_up      <= 1'b1;
            decoder_out <= ONE_HOT0;
            step_pulse  <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (load_ok) begin
                // Load restarts the period and swallows a coincident tick.
                idx         <= load_idx;
                decoder_out <= ONE_HOT0 << load_idx;
                cnt         <= CNT_MAX;
            end else if (en) begin
                cnt <= tick ? CNT_MAX : cnt - 1'b1;
                if (tick && moving) begin
                    idx         <= nxt_idx;
                    decoder_out <= ONE_HOT0 << nxt_idx;
                    dir_up      <= nxt_dir;
                    step_pulse  <= 1'b1;
                    wrap_pulse  <= nxt_wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_one_hot_step_sequencer.sv
// Bench for one_hot_step_sequencer: three sizes driven in lockstep and
// checked every cycle against an arithmetic reference model.
module tb_one_hot_step_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_idx;

    logic [7:0] a_dec;
    logic [2:0] a_idx;
    logic       a_sp, a_wp;
    logic [1:0] b_dec;
    logic [0:0] b_idx;
    logic       b_sp, b_wp;
    logic [5:0] c_dec;
    logic [2:0] c_idx;
    logic       c_sp, c_wp;

    always #5 clk = ~clk;

    one_hot_step_sequencer #(.CLK_FREQ(8), .STEP_HZ(2), .N_OUT(8)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_idx(load_idx), .decoder_out(a_dec), .idx(a_idx),
        .step_pulse(a_sp), .wrap_pulse(a_wp));

    one_hot_step_sequencer #(.CLK_FREQ(8), .STEP_HZ(8), .N_OUT(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_idx(load_idx[0:0]), .decoder_out(b_dec), .idx(b_idx),
        .step_pulse(b_sp), .wrap_pulse(b_wp));

    one_hot_step_sequencer #(.CLK_FREQ(8), .STEP_HZ(2), .N_OUT(6)) u6 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_idx(load_idx), .decoder_out(c_dec), .idx(c_idx),
        .step_pulse(c_sp), .wrap_pulse(c_wp));

    logic [7:0] o_dec [3];
    logic [2:0] o_idx [3];
    logic       o_sp  [3];
    logic       o_wp  [3];

    assign o_dec[0] = a_dec;
    assign o_dec[1] = {6'b0, b_dec};
    assign o_dec[2] = {2'b0, c_dec};
    assign o_idx[0] = a_idx;
    assign o_idx[1] = {2'b0, b_idx};
    assign o_idx[2] = c_idx;
    assign o_sp[0]  = a_sp;
    assign o_sp[1]  = b_sp;
    assign o_sp[2]  = c_sp;
    assign o_wp[0]  = a_wp;
    assign o_wp[1]  = b_wp;
    assign o_wp[2]  = c_wp;

    int n_of [3] = '{8, 2, 6};
    int p_of [3] = '{4, 1, 4};
    int w_of [3] = '{3, 1, 3};

    // Model: rem counts enabled cycles left before the next step.
    int m_idx [3];
    int m_rem [3];
    int m_dir [3];
    bit m_sp  [3];
    bit m_wp  [3];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0;
            m_rem[k] = p_of[k] - 1;
            m_dir[k] = 1;
            m_sp[k]  = 0;
            m_wp[k]  = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int li;
            int nx;
            li = int'(load_idx) % (1 << w_of[k]);
            m_sp[k] = 0;
            m_wp[k] = 0;
            if (load && li < n_of[k]) begin
                m_idx[k] = li;
                m_rem[k] = p_of[k] - 1;
            end else if (en) begin
                if (m_rem[k] > 0) begin
                    m_rem[k]--;
                end else begin
                    m_rem[k] = p_of[k] - 1;
                    case (mode)
                        2'd0: begin
                            m_wp[k]  = (m_idx[k] == n_of[k] - 1);
                            m_idx[k] = (m_idx[k] + 1) % n_of[k];
                            m_sp[k]  = 1;
                        end
                        2'd1: begin
                            m_wp[k]  = (m_idx[k] == 0);
                            m_idx[k] = (m_idx[k] + n_of[k] - 1) % n_of[k];
                            m_sp[k]  = 1;
                        end
                        2'd2: begin
                            nx = m_idx[k] + m_dir[k];
                            if (nx < 0 || nx >= n_of[k]) begin
                                m_dir[k] = -m_dir[k];
                                nx = m_idx[k] + m_dir[k];
                                m_wp[k] = 1;
                            end
                            m_idx[k] = nx;
                            m_sp[k]  = 1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic clock_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0; mode = 2'd0; load = 1'b0; load_idx = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({o_dec[k], o_idx[k], o_sp[k], o_wp[k]} !==
                {8'd1, 3'd0, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset inst%0d got dec=%h idx=%0d sp=%b wp=%b exp dec=01 idx=0 sp=0 wp=0",
                         k, o_dec[k], o_idx[k], o_sp[k], o_wp[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_mode(input string name, input logic [1:0] m,
                             input int cycles);
        mode = m; en = 1'b1; load = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            clock_model();
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if ({o_dec[k], o_idx[k], o_sp[k], o_wp[k]} !==
                    {8'(1 << m_idx[k]), 3'(m_idx[k]), m_sp[k], m_wp[k]}) begin
                    tests_failed++;
                    $display("FAIL %s inst%0d cyc%0d got dec=%h idx=%0d sp=%b wp=%b exp dec=%h idx=%0d sp=%b wp=%b",
                             name, k, c, o_dec[k], o_idx[k], o_sp[k], o_wp[k],
                             8'(1 << m_idx[k]), m_idx[k], m_sp[k], m_wp[k]);
                end
            end
        end
    endtask

    task automatic test_first_step();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; mode = 2'd0; load = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            clock_model();
            tests_run++;
            if (a_dec !== ((c >= 4) ? 8'h02 : 8'h01) || a_sp !== (c == 4)) begin
                tests_failed++;
                $display("FAIL first_step cyc%0d got dec=%h sp=%b", c, a_dec, a_sp);
            end
        end
    endtask

    task automatic test_en_freeze();
        mode = 2'd0; load = 1'b0;
        for (int c = 0; c < 80; c++) begin
            en = (c % 20 < 10) ? 1'b1 : 1'b0;
            if (c >= 40) en = 1'($urandom_range(0, 1));
            clock_model();
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if ({o_dec[k], o_idx[k], o_sp[k], o_wp[k]} !==
                    {8'(1 << m_idx[k]), 3'(m_idx[k]), m_sp[k], m_wp[k]}) begin
                    tests_failed++;
                    $display("FAIL en_freeze inst%0d cyc%0d got dec=%h sp=%b wp=%b exp dec=%h sp=%b wp=%b",
                             k, c, o_dec[k], o_sp[k], o_wp[k],
                             8'(1 << m_idx[k]), m_sp[k], m_wp[k]);
                end
            end
        end
    endtask

    task automatic test_load_and_random(input string name, input int cycles,
                                        input bit rand_mode);
        for (int c = 0; c < cycles; c++) begin
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 5) == 0);
            load_idx = 3'($urandom_range(0, 7));
            if (rand_mode) mode = 2'($urandom_range(0, 3));
            clock_model();
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if ({o_dec[k], o_idx[k], o_sp[k], o_wp[k]} !==
                    {8'(1 << m_idx[k]), 3'(m_idx[k]), m_sp[k], m_wp[k]}) begin
                    tests_failed++;
                    $display("FAIL %s inst%0d cyc%0d got dec=%h idx=%0d sp=%b wp=%b exp dec=%h idx=%0d sp=%b wp=%b",
                             name, k, c, o_dec[k], o_idx[k], o_sp[k], o_wp[k],
                             8'(1 << m_idx[k]), m_idx[k], m_sp[k], m_wp[k]);
                end
            end
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        en = 1'b1; mode = 2'd0; load = 1'b0;
        repeat (7) clock_model();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({o_dec[k], o_idx[k], o_sp[k], o_wp[k]} !==
                {8'd1, 3'd0, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL async_reset inst%0d got dec=%h idx=%0d sp=%b wp=%b exp dec=01 idx=0 sp=0 wp=0",
                         k, o_dec[k], o_idx[k], o_sp[k], o_wp[k]);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode("rotate_up", 2'd0, 40);
        test_first_step();
        test_mode("rotate_down", 2'd1, 36);
        test_mode("bounce", 2'd2, 70);
        test_mode("hold", 2'd3, 12);
        test_en_freeze();
        mode = 2'd0;
        test_load_and_random("load", 80, 1'b0);
        mode = 2'd2;
        test_load_and_random("load_bounce", 60, 1'b0);
        test_load_and_random("random", 400, 1'b1);
        test_async_reset();
        test_mode("after_reset", 2'd1, 20);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
